// File: rtl/vid_timing_pkg.sv
// Shared types for the video timing generator/detector pair.
// Counts, detector states and the frame-geometry bundle.
package vid_timing_pkg;

  localparam int CNT_W = 12;

  typedef logic [CNT_W-1:0] cnt_t;

  localparam cnt_t CNT_MAX = 12'd4095;

  typedef enum logic [1:0] {
    SEARCH,
    MEASURE,
    VERIFY,
    LOCKED
  } det_state_t;

  typedef struct packed {
    cnt_t h_total;
    cnt_t h_active;
    cnt_t v_total;
    cnt_t v_active;
  } geom_t;

  function automatic cnt_t sat_inc(cnt_t v);
    return (v == CNT_MAX) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/vid_sync_edge.sv
// Input register stage for the video stream.
// Normalises sync polarity and flags rising edges of hs/vs/de.
module vid_sync_edge #(
  parameter int DATA_W          = 24,
  parameter bit SYNC_ACTIVE_LOW = 1'b1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              vid_hs,
  input  logic              vid_vs,
  input  logic              vid_de,
  input  logic [DATA_W-1:0] vid_data,
  output logic              de,
  output logic [DATA_W-1:0] data,
  output logic              hs_edge,
  output logic              vs_edge,
  output logic              de_rise
);

  logic hs;
  logic vs;
  logic hs_p;
  logic vs_p;
  logic de_p;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hs   <= 1'b0;
      vs   <= 1'b0;
      de   <= 1'b0;
      data <= '0;
      hs_p <= 1'b0;
      vs_p <= 1'b0;
      de_p <= 1'b0;
    end else begin
      hs   <= vid_hs ^ SYNC_ACTIVE_LOW;
      vs   <= vid_vs ^ SYNC_ACTIVE_LOW;
      de   <= vid_de;
      data <= vid_data;
      hs_p <= hs;
      vs_p <= vs;
      de_p <= de;
    end
  end

  assign hs_edge = hs & ~hs_p;
  assign vs_edge = vs & ~vs_p;
  assign de_rise = de & ~de_p;

endmodule

// File: rtl/vga_timing_detector.sv
// Measures incoming video geometry, locks on stable frames
// and re-emits active pixels tagged with x/y and frame markers.
module vga_timing_detector
  import vid_timing_pkg::*;
#(
  parameter int DATA_W          = 24,
  parameter int LOCK_FRAMES     = 3,
  parameter bit SYNC_ACTIVE_LOW = 1'b1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              vid_hs,
  input  logic              vid_vs,
  input  logic              vid_de,
  input  logic [DATA_W-1:0] vid_data,
  output logic              pix_valid,
  output logic [DATA_W-1:0] pix_data,
  output logic [11:0]       pix_x,
  output logic [11:0]       pix_y,
  output logic              pix_sof,
  output logic              pix_eol,
  output logic [11:0]       meas_h_total,
  output logic [11:0]       meas_h_active,
  output logic [11:0]       meas_v_total,
  output logic [11:0]       meas_v_active,
  output logic              locked
);

  localparam int MW = $clog2(LOCK_FRAMES + 1);
  localparam logic [MW-1:0] MATCH_LAST = MW'(LOCK_FRAMES - 1);

  logic              de_r;
  logic [DATA_W-1:0] data_r;
  logic              hs_edge;
  logic              vs_edge;
  logic              de_rise;

  vid_sync_edge #(
    .DATA_W          (DATA_W),
    .SYNC_ACTIVE_LOW (SYNC_ACTIVE_LOW)
  ) u_sync (
    .clk      (clk),
    .reset_n  (reset_n),
    .vid_hs   (vid_hs),
    .vid_vs   (vid_vs),
    .vid_de   (vid_de),
    .vid_data (vid_data),
    .de       (de_r),
    .data     (data_r),
    .hs_edge  (hs_edge),
    .vs_edge  (vs_edge),
    .de_rise  (de_rise)
  );

  cnt_t h_cnt;
  cnt_t de_cnt;
  cnt_t v_cnt;
  cnt_t v_snap;
  cnt_t act_lines;
  cnt_t line_total;
  cnt_t line_active;
  logic hs_seen;
  logic frame_eval;
  logic line_done;

  assign line_done = hs_edge & hs_seen & (de_cnt != '0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      h_cnt       <= '0;
      de_cnt      <= '0;
      v_cnt       <= '0;
      v_snap      <= '0;
      act_lines   <= '0;
      line_total  <= '0;
      line_active <= '0;
      hs_seen     <= 1'b0;
      frame_eval  <= 1'b0;
    end else begin
      h_cnt <= hs_edge ? '0 : sat_inc(h_cnt);
      if (hs_edge)
        de_cnt <= {{(CNT_W-1){1'b0}}, de_r};
      else if (de_r)
        de_cnt <= sat_inc(de_cnt);
      if (hs_edge)
        hs_seen <= 1'b1;
      if (hs_edge && hs_seen)
        line_total <= h_cnt + 1'b1;
      if (line_done)
        line_active <= de_cnt;
      // A line closing on the eval cycle opens the new frame's count.
      if (frame_eval)
        act_lines <= {{(CNT_W-1){1'b0}}, line_done};
      else if (line_done)
        act_lines <= sat_inc(act_lines);
      if (vs_edge)
        v_cnt <= {{(CNT_W-1){1'b0}}, hs_edge};
      else if (hs_edge)
        v_cnt <= sat_inc(v_cnt);
      if (vs_edge)
        v_snap <= v_cnt;
      frame_eval <= vs_edge;
    end
  end

  geom_t      cand;
  geom_t      meas;
  geom_t      meas_n;
  det_state_t state;
  det_state_t state_n;
  logic [MW-1:0] match_cnt;
  logic [MW-1:0] match_n;
  logic       locked_n;
  logic       timeout;

  assign cand = '{h_total:  line_total,
                  h_active: line_active,
                  v_total:  v_snap,
                  v_active: act_lines};

  assign timeout = (h_cnt == CNT_MAX) ||
                   ((v_cnt == CNT_MAX) && !vs_edge);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= SEARCH;
      meas      <= '0;
      match_cnt <= '0;
      locked    <= 1'b0;
    end else begin
      state     <= state_n;
      meas      <= meas_n;
      match_cnt <= match_n;
      locked    <= locked_n;
    end
  end

  always_comb begin
    state_n  = state;
    meas_n   = meas;
    match_n  = match_cnt;
    locked_n = locked;
    if (timeout) begin
      state_n  = SEARCH;
      meas_n   = '0;
      match_n  = '0;
      locked_n = 1'b0;
    end else if (frame_eval) begin
      unique case (state)
        SEARCH: state_n = MEASURE;
        MEASURE: begin
          meas_n  = cand;
          match_n = '0;
          state_n = VERIFY;
        end
        VERIFY: begin
          if (cand == meas) begin
            match_n = match_cnt + 1'b1;
            if (match_cnt == MATCH_LAST) begin
              state_n  = LOCKED;
              locked_n = 1'b1;
            end
          end else begin
            meas_n  = cand;
            match_n = '0;
          end
        end
        LOCKED: begin
          if (cand != meas) begin
            locked_n = 1'b0;
            meas_n   = cand;
            match_n  = '0;
            state_n  = VERIFY;
          end
        end
        default: state_n = SEARCH;
      endcase
    end
  end

  assign meas_h_total  = meas.h_total;
  assign meas_h_active = meas.h_active;
  assign meas_v_total  = meas.v_total;
  assign meas_v_active = meas.v_active;

  logic first_pend;
  cnt_t x_n;
  cnt_t y_n;

  always_comb begin
    x_n = pix_x;
    y_n = pix_y;
    if (de_rise) begin
      x_n = '0;
      y_n = (first_pend || vs_edge) ? '0 : sat_inc(pix_y);
    end else if (de_r) begin
      x_n = sat_inc(pix_x);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pix_valid  <= 1'b0;
      pix_data   <= '0;
      pix_x      <= '0;
      pix_y      <= '0;
      first_pend <= 1'b0;
    end else begin
      pix_valid <= de_r;
      pix_data  <= data_r;
      pix_x     <= x_n;
      pix_y     <= y_n;
      if (de_rise)
        first_pend <= 1'b0;
      else if (vs_edge)
        first_pend <= 1'b1;
    end
  end

  assign pix_sof = pix_valid & (pix_x == '0) & (pix_y == '0);
  assign pix_eol = pix_valid & ~de_r;

endmodule

// File: tb/tb_vga_timing_detector.sv
// Directed bench: 20x10 frames, scoreboard on the pixel path,
// lock/timeout/reset checks on the measurement side.
module tb_vga_timing_detector;
  import vid_timing_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        vid_hs;
  logic        vid_vs;
  logic        vid_de;
  logic [23:0] vid_data;
  logic        pix_valid;
  logic [23:0] pix_data;
  logic [11:0] pix_x;
  logic [11:0] pix_y;
  logic        pix_sof;
  logic        pix_eol;
  logic [11:0] meas_h_total;
  logic [11:0] meas_h_active;
  logic [11:0] meas_v_total;
  logic [11:0] meas_v_active;
  logic        locked;

  vga_timing_detector #(
    .DATA_W          (24),
    .LOCK_FRAMES     (3),
    .SYNC_ACTIVE_LOW (1'b1)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .vid_hs        (vid_hs),
    .vid_vs        (vid_vs),
    .vid_de        (vid_de),
    .vid_data      (vid_data),
    .pix_valid     (pix_valid),
    .pix_data      (pix_data),
    .pix_x         (pix_x),
    .pix_y         (pix_y),
    .pix_sof       (pix_sof),
    .pix_eol       (pix_eol),
    .meas_h_total  (meas_h_total),
    .meas_h_active (meas_h_active),
    .meas_v_total  (meas_v_total),
    .meas_v_active (meas_v_active),
    .locked        (locked)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [23:0] d;
    logic [11:0] x;
    logic [11:0] y;
    logic        sof;
    logic        eol;
  } px_t;

  px_t sbq[$];
  px_t mon_e;
  px_t mon_g;
  bit  sb_en = 1'b0;
  int  checks = 0;
  int  failures = 0;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic zero_chk(input string tag);
    chk({tag, "_valid"}, pix_valid, 0);
    chk({tag, "_data"}, pix_data, 0);
    chk({tag, "_x"}, pix_x, 0);
    chk({tag, "_y"}, pix_y, 0);
    chk({tag, "_sof"}, pix_sof, 0);
    chk({tag, "_eol"}, pix_eol, 0);
    chk({tag, "_htot"}, meas_h_total, 0);
    chk({tag, "_hact"}, meas_h_active, 0);
    chk({tag, "_vtot"}, meas_v_total, 0);
    chk({tag, "_vact"}, meas_v_active, 0);
    chk({tag, "_locked"}, locked, 0);
  endtask

  task automatic meas_chk(input string tag, input int hact);
    chk({tag, "_htot"}, meas_h_total, 20);
    chk({tag, "_hact"}, meas_h_active, hact);
    chk({tag, "_vtot"}, meas_v_total, 10);
    chk({tag, "_vact"}, meas_v_active, 6);
  endtask

  task automatic tick(input logic hs, input logic vs,
                      input logic de, input logic [23:0] d);
    vid_hs   = hs;
    vid_vs   = vs;
    vid_de   = de;
    vid_data = d;
    @(posedge clk);
    #1;
  endtask

  // mode: 0 plain, 1 expect lock rise, 2 expect lock fall,
  // 3 pulse reset mid-frame
  task automatic frame(input int h_act, input int mode);
    int rst_left = 0;
    for (int ln = 0; ln < 10; ln++) begin
      for (int c = 0; c < 20; c++) begin
        bit          act;
        logic [23:0] d;
        px_t         e;
        act = (ln >= 2) && (ln < 8) && (c >= 4) && (c < 4 + h_act);
        d   = 24'($urandom);
        if (act && sb_en) begin
          e.d   = d;
          e.x   = 12'(c - 4);
          e.y   = 12'(ln - 2);
          e.sof = (c == 4) && (ln == 2);
          e.eol = (c == 3 + h_act);
          sbq.push_back(e);
        end
        tick(!(c < 2), !(ln < 2), act, d);
        if (rst_left > 0) begin
          rst_left--;
          if (rst_left == 0)
            reset_n = 1'b1;
        end
        if (ln == 0 && c == 0 && (mode == 1 || mode == 2))
          chk("lock_before_eval", locked, (mode == 1) ? 0 : 1);
        if (ln == 0 && c == 2 && (mode == 1 || mode == 2))
          chk("lock_after_eval", locked, (mode == 1) ? 1 : 0);
        if (mode == 3 && ln == 4 && c == 8) begin
          sb_en = 1'b0;
          sbq.delete();
          reset_n = 1'b0;
          #1;
          zero_chk("midrst");
          rst_left = 3;
        end
      end
    end
  endtask

  always @(negedge clk) begin
    if (sb_en && pix_valid) begin
      if (sbq.size() == 0) begin
        chk("pix_unexpected", pix_valid, 0);
      end else begin
        mon_e = sbq.pop_front();
        mon_g = {pix_data, pix_x, pix_y, pix_sof, pix_eol};
        chk("pix", mon_g, mon_e);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n  = 1'b0;
    vid_hs   = 1'b1;
    vid_vs   = 1'b1;
    vid_de   = 1'b0;
    vid_data = '0;
    repeat (3) @(posedge clk);
    #1;
    zero_chk("reset");
    chk("reset_state", dut.state, SEARCH);
    reset_n = 1'b1;
    tick(1'b1, 1'b1, 1'b0, '0);

    sb_en = 1'b1;
    repeat (4) frame(12, 0);
    chk("no_lock_4vs", locked, 0);
    frame(12, 1);
    frame(12, 0);
    meas_chk("lock1", 12);
    chk("lock1_locked", locked, 1);
    chk("sb_drain1", sbq.size(), 0);

    frame(10, 0);
    frame(10, 2);
    meas_chk("hchg", 10);
    frame(10, 0);
    frame(10, 0);
    chk("hchg_not_yet", locked, 0);
    frame(10, 1);
    chk("hchg_relock", locked, 1);
    meas_chk("hchg_relock", 10);

    repeat (4100) tick(1'b1, 1'b1, 1'b0, '0);
    chk("tmo_locked", locked, 0);
    chk("tmo_htot", meas_h_total, 0);
    chk("tmo_hact", meas_h_active, 0);
    chk("tmo_vtot", meas_v_total, 0);
    chk("tmo_vact", meas_v_active, 0);
    chk("tmo_state", dut.state, SEARCH);

    repeat (4) frame(12, 0);
    chk("tmo_no_lock", locked, 0);
    frame(12, 1);
    meas_chk("tmo_relock", 12);

    frame(12, 3);
    sb_en = 1'b1;
    repeat (4) frame(12, 0);
    chk("rst_no_lock", locked, 0);
    frame(12, 1);
    meas_chk("rst_relock", 12);
    chk("sb_drain2", sbq.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
